// File: rtl/data_mem_resp.sv
// Single-port data memory with a fixed-latency valid/ready response path (IDLE -> WAIT -> RESP).
// Optional alignment checking via macro DATA_MEM_MISALIGN_CHECK_EN; otherwise misaligned accesses are force-aligned.
module data_mem_resp #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_sign_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o
);
    localparam logic [3:0] P_LAT = 4'(LATENCY);
    localparam int         DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_rdy_en;
    logic                  r_write;
    logic                  r_sign;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_type;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_op_write;
    logic                  w_op_sign;
    logic [ADDR_WIDTH+1:0] w_op_addr;
    logic [31:0]           w_op_wdata;
    logic [1:0]            w_op_type;
    logic                  w_is_half;
    logic                  w_is_word;
    logic                  w_err;
    logic [1:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wlane;
    logic                  w_do_write;
    logic [31:0]           w_rword;
    logic [31:0]           w_shifted;
    logic [31:0]           w_load;
    logic [31:0]           w_rdata_nxt;
    logic                  w_unused_addr;

    assign req_ready_o  = (r_state == S_IDLE) & r_rdy_en;
    assign resp_valid_o = (r_state == S_RESP);
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;
    assign w_accept     = req_valid_i & req_ready_o;
    assign w_unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];

    // With zero latency the access executes on the acceptance edge, so use the live request fields.
    assign w_op_write = (r_state == S_IDLE) ? req_write_i : r_write;
    assign w_op_sign  = (r_state == S_IDLE) ? req_sign_i : r_sign;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr_i[ADDR_WIDTH+1:0] : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata_i : r_wdata;
    assign w_op_type  = (r_state == S_IDLE) ? req_type_i : r_type;

    assign w_enter_resp = ((r_state == S_IDLE) & w_accept & (P_LAT == 4'd0)) |
                          ((r_state == S_WAIT) & (r_cnt <= 4'd1));

    assign w_is_half = (w_op_type == 2'b01);
    assign w_is_word = w_op_type[1];
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    assign w_err = (w_is_half & w_op_addr[0]) | (w_is_word & (|w_op_addr[1:0]));
`else
    assign w_err = 1'b0;
`endif
    assign w_off   = w_is_word ? 2'b00 : (w_is_half ? {w_op_addr[1], 1'b0} : w_op_addr[1:0]);
    assign w_idx   = w_op_addr[ADDR_WIDTH+1:2];
    assign w_be    = w_is_word ? 4'hF : (w_is_half ? (4'b0011 << w_off) : (4'b0001 << w_off));
    assign w_wlane = w_is_word ? w_op_wdata :
                     (w_is_half ? {2{w_op_wdata[15:0]}} : {4{w_op_wdata[7:0]}});
    assign w_do_write = w_enter_resp & w_op_write & ~w_err & ~rst_i;

    assign w_rword   = r_mem[w_idx];
    assign w_shifted = w_rword >> {w_off, 3'b000};
    assign w_load    = w_is_word ? w_rword :
                       (w_is_half ? {{16{w_op_sign & w_shifted[15]}}, w_shifted[15:0]}
                                  : {{24{w_op_sign & w_shifted[7]}}, w_shifted[7:0]});
    assign w_rdata_nxt = (w_op_write | w_err) ? 32'd0 : w_load;

    // Storage is deliberately left out of reset so contents survive an aborted access.
    always_ff @(posedge clk_i) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (P_LAT == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt <= 4'd1) w_state_nxt = S_RESP;
            S_RESP:  if (resp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdy_en <= 1'b0;
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_sign   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_type   <= 2'b00;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                r_cnt   <= P_LAT;
                r_write <= req_write_i;
                r_sign  <= req_sign_i;
                r_addr  <= req_addr_i[ADDR_WIDTH+1:0];
                r_wdata <= req_wdata_i;
                r_type  <= req_type_i;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_rdata_nxt;
                r_err   <= w_err;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: scoreboard of expected responses built from a byte-level memory model.
module tb_data_mem_resp;
    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_type_i;
    logic        req_sign_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    always #5 clk_i = ~clk_i;

    data_mem_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_type_i(req_type_i), .req_sign_i(req_sign_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [7:0]  mdl[int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] ty, input bit sg, output exp_t e);
        int nb;
        int ba;
        logic [31:0] v;
        nb = (ty == 2'd0) ? 1 : ((ty == 2'd1) ? 2 : 4);
        ba = int'(a[AW+1:0]);
        e.rdata = 32'd0;
        e.err   = 1'b0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        if ((ba % nb) != 0) begin
            e.err = 1'b1;
            return;
        end
`endif
        ba = ba - (ba % nb);
        if (wr) begin
            for (int i = 0; i < nb; i++) mdl[ba + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl.exists(ba + i) ? mdl[ba + i] : 8'h00;
            if (sg && (nb < 4) && v[8*nb - 1]) begin
                for (int i = 8 * nb; i < 32; i++) v[i] = 1'b1;
            end
            e.rdata = v;
        end
    endtask

    // One full transaction; 'hold' stalls resp_ready_i while a rival request is offered.
    task automatic txn(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] ty, input bit sg, input int hold);
        exp_t e;
        exp_t got_e;
        int   n;
        bit   got;
        logic [31:0] held;
        model(wr, a, wd, ty, sg, e);
        sb.push_back(e);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = a;
        req_wdata_i = wd;   req_type_i = ty;  req_sign_i = sg;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_write_i = ~wr;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        req_type_i  = 2'($urandom_range(0, 3));
        req_sign_i  = ~sg;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk_i);
            n++;
            if (resp_valid_o) got = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
        got_e = sb.pop_front();
        check({tag, "_rdata"}, resp_rdata_o, got_e.rdata);
        check({tag, "_err"}, 32'(resp_err_o), 32'(got_e.err));
        held = resp_rdata_o;
        for (int k = 0; k < hold; k++) begin
            req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h40;
            req_wdata_i = 32'h0BAD_BADB; req_type_i = 2'b10;
            @(negedge clk_i);
            check({tag, "_hold_valid"}, 32'(resp_valid_o), 32'd1);
            check({tag, "_hold_rdata"}, resp_rdata_o, held);
            check({tag, "_hold_ready"}, 32'(req_ready_o), 32'd0);
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        check({tag, "_done_valid"}, 32'(resp_valid_o), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = 32'd0;
        req_wdata_i = 32'd0; req_type_i = 2'b00; req_sign_i = 1'b0; resp_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 32'(resp_valid_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_rdata", resp_rdata_o, 32'd0);
        check("rst_err", 32'(resp_err_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("rel_ready_before_edge", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        check("rel_ready_after_edge", 32'(req_ready_o), 32'd1);

        txn("st_word", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 0);
        txn("ld_word", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0);
        txn("st_byte", 1'b1, 32'h13, 32'h0000_005A, 2'b00, 1'b0, 0);
        txn("ld_byte_u", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0);
        txn("ld_half_s", 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 0);
        txn("ld_word2", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0);
        txn("ld_byte_s", 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 0);
        txn("st_half", 1'b1, 32'h16, 32'hFFFF_8001, 2'b01, 1'b0, 0);
        txn("ld_half_u", 1'b0, 32'h16, 32'h0, 2'b01, 1'b0, 0);
        txn("ld_rsvd", 1'b0, 32'h10, 32'h0, 2'b11, 1'b1, 0);

        txn("st_40", 1'b1, 32'h40, 32'h1234_5678, 2'b10, 1'b0, 0);
        txn("ld_40_hold", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 5);
        txn("ld_40_after", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 0);

        txn("st_20", 1'b1, 32'h20, 32'h2222_2222, 2'b10, 1'b0, 0);
        txn("ld_20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h20;
        req_wdata_i = 32'h1111_1111; req_type_i = 2'b10; req_sign_i = 1'b0;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("abort_valid", 32'(resp_valid_o), 32'd0);
        check("abort_ready", 32'(req_ready_o), 32'd0);
        check("abort_rdata", resp_rdata_o, 32'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("abort_valid_held", 32'(resp_valid_o), 32'd0);
        rst_i = 1'b0;
        txn("ld_20_after_abort", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0);

        txn("st_misalign", 1'b1, 32'h22, 32'hA5A5_A5A5, 2'b10, 1'b0, 0);
        txn("ld_20_misalign", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0);
        txn("ld_half_odd", 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 0);

        txn("st_wrap", 1'b1, 32'h1004, 32'hCAFE_F00D, 2'b10, 1'b0, 0);
        txn("ld_wrap", 1'b0, 32'h0004, 32'h0, 2'b10, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
